// File: rtl/pulse_channel_scheduler.sv
// pulse_channel_scheduler
//   Time-multiplexed pulse-width measurement for several RC/servo inputs.
//   One prescaler and one tick counter are shared by all channels. The FSM
//   visits channels round-robin, waits for a full rising edge, counts ticks
//   while the selected input stays high, and stores the result (or a
//   zero/invalid entry on timeout) in a per-channel register bank.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   pulse_in   raw asynchronous pulse inputs, one per channel
//   enable     scanning enable, sampled in IDLE and at the end of STORE
//   rd_chan    register-bank read select
//   rd_value   stored tick count for rd_chan (combinational)
//   rd_valid   stored value for rd_chan came from a good measurement
//   cur_chan   channel currently being serviced
//   busy       FSM is not in IDLE
//   out_stb    one-cycle strobe, high in the cycle after a bank write
//   out_chan   index of the entry written, valid while out_stb is high
//   state_dbg  current FSM state encoding (IDLE=0 .. STORE=4)
//
// Handshake: out_stb/out_chan form a valid-only event stream with no ready.
// A consumer that needs the value must sample it while out_stb is high; the
// bank already holds the new entry in that same cycle.

module pulse_channel_scheduler #(
   parameter int CHANNELS = 4,
   parameter int PREDIV   = 50,
   parameter int MAXV     = 4096,
   localparam int W       = $clog2(MAXV),
   localparam int CW      = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] pulse_in,
   input  logic                enable,
   input  logic [CW-1:0]       rd_chan,
   output logic [W-1:0]        rd_value,
   output logic                rd_valid,
   output logic [CW-1:0]       cur_chan,
   output logic                busy,
   output logic                out_stb,
   output logic [CW-1:0]       out_chan,
   output logic [2:0]          state_dbg
);

   localparam int PW = $clog2(PREDIV);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOW  = 3'd1,
      ST_WAIT_HIGH = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_STORE     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CHANNELS-1:0] sync1_q, sync2_q;
   logic [PW-1:0]       pre_q, pre_d;
   logic [W-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]       cur_q;
   logic                stb_q;
   logic [CW-1:0]       out_chan_q;
   logic [W-1:0]        bank_q [CHANNELS];
   logic [CHANNELS-1:0] valid_q;

   logic                s;
   logic                tick;
   logic                timeout;
   logic                wr_en;
   logic                wr_ok;
   logic [W-1:0]        wr_val;

   assign s       = sync2_q[cur_q];
   assign tick    = (pre_q == PW'(PREDIV - 1));
   assign timeout = tick && (cnt_q == W'(MAXV - 1));

   // Next-state logic. The bank is written on the edge that enters STORE,
   // so out_stb (registered) and the new bank contents appear together.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      wr_ok   = 1'b0;
      wr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (timeout) begin
               state_d = ST_STORE;
               wr_en   = 1'b1;
            end else if (!s) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (timeout) begin
               state_d = ST_STORE;
               wr_en   = 1'b1;
            end else if (s) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (timeout) begin
               state_d = ST_STORE;
               wr_en   = 1'b1;
            end else if (!s) begin
               // The rising edge was seen one cycle before MEASURE began, so
               // a tick in the falling-edge cycle still belongs to the pulse.
               state_d = ST_STORE;
               wr_en   = 1'b1;
               wr_ok   = 1'b1;
               wr_val  = cnt_q + W'(tick);
            end
         end
         ST_STORE: begin
            state_d = enable ? ST_WAIT_LOW : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shared timer restarts on every state change.
   always_comb begin
      pre_d = pre_q + PW'(1);
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sync1_q    <= '0;
         sync2_q    <= '0;
         pre_q      <= '0;
         cnt_q      <= '0;
         cur_q      <= '0;
         stb_q      <= 1'b0;
         out_chan_q <= '0;
         valid_q    <= '0;
         for (int i = 0; i < CHANNELS; i++) bank_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sync1_q <= pulse_in;
         sync2_q <= sync1_q;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         stb_q   <= wr_en;
         if (wr_en) begin
            bank_q[cur_q]  <= wr_val;
            valid_q[cur_q] <= wr_ok;
            out_chan_q     <= cur_q;
         end
         if (state_q == ST_STORE) begin
            cur_q <= (cur_q == CW'(CHANNELS - 1)) ? '0 : cur_q + CW'(1);
         end
      end
   end

   assign rd_value  = (int'(rd_chan) < CHANNELS) ? bank_q[rd_chan] : '0;
   assign rd_valid  = (int'(rd_chan) < CHANNELS) ? valid_q[rd_chan] : 1'b0;
   assign cur_chan  = cur_q;
   assign busy      = (state_q != ST_IDLE);
   assign out_stb   = stb_q;
   assign out_chan  = out_chan_q;
   assign state_dbg = state_q;

endmodule
